// File: rtl/lc3b_pkg.sv
// Shared LC-3b datapath constants and types.
package lc3b_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;

    // Condition codes after reset: Z set, so nzp is one-hot from the start
    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3b_dec3to8.sv
// Index-to-one-hot decoder with enable; produces the per-register write strobes.
module lc3b_dec3to8 #(
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                en,
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    // Exactly one strobe when enabled, none otherwise
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lc3b_regfile.sv
// LC-3b general register file (R0..R7) with NZP condition codes.
// Two combinational read ports, one write port steered by a one-hot decoder.
// Optional build macro REGFILE_BYPASS_EN: a read port whose index matches a
// write in progress returns wr_data in the same cycle (nzp is never bypassed).
module lc3b_regfile #(
    parameter int unsigned DATA_W   = lc3b_pkg::DATA_W,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = lc3b_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_reg,
    input  logic [IDX_W-1:0]  dr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_cc,
    input  logic [IDX_W-1:0]  sr1,
    input  logic [IDX_W-1:0]  sr2,
    output logic [DATA_W-1:0] sr1_out,
    output logic [DATA_W-1:0] sr2_out,
    output logic [2:0]        nzp
);

    import lc3b_pkg::*;

    logic [NUM_REGS-1:0] wr_stb;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [2:0]          nzp_q;
    logic [2:0]          nzp_d;
    logic                cc_n;
    logic                cc_z;

    lc3b_dec3to8 #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .en     (ld_reg),
        .idx    (dr),
        .onehot (wr_stb)
    );

    // Next register contents: strobed register takes wr_data, others hold
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_stb[i] ? wr_data : regs_q[i];
        end
    end

    // Register array; async reset clears everything and discards a pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Condition codes derived from the bus value; p is the residual case so nzp stays one-hot
    always_comb begin
        cc_n  = wr_data[DATA_W-1];
        cc_z  = (wr_data == '0);
        nzp_d = nzp_q;
        if (ld_cc) begin
            nzp_d = {cc_n, cc_z, ~cc_n & ~cc_z};
        end
    end

    // Condition-code register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzp_q <= NZP_RESET;
        end else begin
            nzp_q <= nzp_d;
        end
    end

    // Read ports; bypass is suppressed during reset so both ports read zero immediately
    always_comb begin
        sr1_out = regs_q[sr1];
        sr2_out = regs_q[sr2];
`ifdef REGFILE_BYPASS_EN
        if (!reset && ld_reg && (dr == sr1)) begin
            sr1_out = wr_data;
        end
        if (!reset && ld_reg && (dr == sr2)) begin
            sr2_out = wr_data;
        end
`else
`endif
    end

    assign nzp = nzp_q;

endmodule

// File: tb/tb_lc3b_regfile.sv
// Self-checking bench for lc3b_regfile: directed vector table, hand-written
// corner sequences (same-cycle write/read, mid-cycle reset) and random traffic
// against an array reference model.
module tb_lc3b_regfile;

    import lc3b_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     reset;
    logic     ld_reg;
    reg_idx_t dr;
    word_t    wr_data;
    logic     ld_cc;
    reg_idx_t sr1;
    reg_idx_t sr2;
    word_t    sr1_out;
    word_t    sr2_out;
    logic [2:0] nzp;

    lc3b_regfile #(
        .DATA_W   (16),
        .NUM_REGS (8),
        .IDX_W    (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ld_reg  (ld_reg),
        .dr      (dr),
        .wr_data (wr_data),
        .ld_cc   (ld_cc),
        .sr1     (sr1),
        .sr2     (sr2),
        .sr1_out (sr1_out),
        .sr2_out (sr2_out),
        .nzp     (nzp)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model
    word_t      mdl [8];
    logic [2:0] mnzp;

    typedef struct {
        logic       ld_reg;
        reg_idx_t   dr;
        word_t      wr;
        logic       ld_cc;
        reg_idx_t   sr1;
        reg_idx_t   sr2;
        word_t      e1;
        word_t      e2;
        logic [2:0] enzp;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [2:0] cc_of(input word_t v);
        if ($signed(v) < 0) return 3'b100;
        else if (v == 16'd0) return 3'b010;
        else return 3'b001;
    endfunction

    function automatic word_t exp_rd(input reg_idx_t sel);
        if (BYP && ld_reg && !reset && (dr == sel)) return wr_data;
        return mdl[sel];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mnzp = 3'b010;
    endtask

    // One clocked step: drive at negedge, check reads before and after the edge
    task automatic apply(input logic a_ld, input reg_idx_t a_dr, input word_t a_wr,
                         input logic a_cc, input reg_idx_t a_s1, input reg_idx_t a_s2,
                         input bit full);
        @(negedge clk);
        ld_reg = a_ld; dr = a_dr; wr_data = a_wr; ld_cc = a_cc; sr1 = a_s1; sr2 = a_s2;
        #1;
        check("pre_sr1", sr1_out, exp_rd(a_s1));
        check("pre_sr2", sr2_out, exp_rd(a_s2));
        @(posedge clk);
        if (a_ld) mdl[a_dr] = a_wr;
        if (a_cc) mnzp = cc_of(a_wr);
        #1;
        check("post_sr1", sr1_out, mdl[a_s1]);
        check("post_sr2", sr2_out, mdl[a_s2]);
        check("nzp", {13'd0, nzp}, {13'd0, mnzp});
        if (full) check("nzp_onehot", {15'd0, $onehot(nzp)}, 16'd1);
    endtask

    function automatic void add(input logic l, input reg_idx_t d, input word_t w, input logic c,
                                input reg_idx_t s1, input reg_idx_t s2,
                                input word_t e1, input word_t e2, input logic [2:0] en);
        vec_t v;
        v.ld_reg = l; v.dr = d; v.wr = w; v.ld_cc = c; v.sr1 = s1; v.sr2 = s2;
        v.e1 = e1; v.e2 = e2; v.enzp = en;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: expected values are the post-edge outputs
        for (int i = 0; i < 8; i++)
            add(1'b1, 3'(i), 16'h1110 + 16'(i), 1'b0, 3'(i), 3'(i),
                16'h1110 + 16'(i), 16'h1110 + 16'(i), 3'b010);
        for (int i = 0; i < 8; i++)
            add(1'b0, 3'(i), 16'hDEAD, 1'b0, 3'(i), 3'(7 - i),
                16'h1110 + 16'(i), 16'h1110 + 16'(7 - i), 3'b010);
        add(1'b0, 3'd0, 16'h8000, 1'b1, 3'd0, 3'd1, 16'h1110, 16'h1111, 3'b100);
        add(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd1, 16'h1110, 16'h1111, 3'b010);
        add(1'b0, 3'd0, 16'h7FFF, 1'b1, 3'd0, 3'd1, 16'h1110, 16'h1111, 3'b001);
        add(1'b0, 3'd0, 16'h8000, 1'b0, 3'd0, 3'd1, 16'h1110, 16'h1111, 3'b001);
        add(1'b1, 3'd7, 16'h00A5, 1'b0, 3'd7, 3'd7, 16'h00A5, 16'h00A5, 3'b001);
        add(1'b0, 3'd7, 16'hFFFF, 1'b0, 3'd7, 3'd7, 16'h00A5, 16'h00A5, 3'b001);
        add(1'b1, 3'd6, 16'hFFFE, 1'b1, 3'd6, 3'd7, 16'hFFFE, 16'h00A5, 3'b100);

        // Power-on reset state
        reset = 1'b1; ld_reg = 1'b0; dr = '0; wr_data = '0; ld_cc = 1'b0; sr1 = 3'd0; sr2 = 3'd7;
        model_reset();
        #1;
        check("rst_sr1", sr1_out, 16'h0000);
        check("rst_sr2", sr2_out, 16'h0000);
        check("rst_nzp", {13'd0, nzp}, 16'h0002);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        foreach (tbl[k]) begin
            apply(tbl[k].ld_reg, tbl[k].dr, tbl[k].wr, tbl[k].ld_cc, tbl[k].sr1, tbl[k].sr2, 1'b1);
            check($sformatf("tbl%0d_sr1", k), sr1_out, tbl[k].e1);
            check($sformatf("tbl%0d_sr2", k), sr2_out, tbl[k].e2);
            check($sformatf("tbl%0d_nzp", k), {13'd0, nzp}, {13'd0, tbl[k].enzp});
        end

        // Same-cycle read of the register being written
        @(negedge clk);
        ld_reg = 1'b1; dr = 3'd5; wr_data = 16'h8001; ld_cc = 1'b0; sr1 = 3'd5; sr2 = 3'd4;
        #1;
        check("raw_same_cycle", sr1_out, BYP ? 16'h8001 : 16'h1115);
        check("raw_other_port", sr2_out, 16'h1114);
        @(posedge clk);
        mdl[5] = 16'h8001;
        #1;
        check("raw_after_edge", sr1_out, 16'h8001);

        // Asynchronous reset mid-cycle with a write pending to R3
        @(negedge clk);
        ld_reg = 1'b1; dr = 3'd3; wr_data = 16'hBEEF; ld_cc = 1'b1; sr1 = 3'd3; sr2 = 3'd3;
        #1;
        check("pre_rst_r3", sr1_out, BYP ? 16'hBEEF : 16'h1113);
        #1;
        reset = 1'b1;
        #1;
        check("arst_sr1", sr1_out, 16'h0000);
        check("arst_sr2", sr2_out, 16'h0000);
        check("arst_nzp", {13'd0, nzp}, 16'h0002);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_edge_r3", sr1_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; sr1 = 3'd3; sr2 = 3'd5;
        #1;
        check("arst_r3_dropped", sr1_out, 16'h0000);
        check("arst_r5_cleared", sr2_out, 16'h0000);
        check("arst_nzp_held", {13'd0, nzp}, 16'h0002);

        // Random traffic against the reference model
        for (int c = 0; c < 10000; c++) begin
            logic     l, cc;
            reg_idx_t d, s1, s2;
            word_t    w;
            l  = 1'($urandom_range(0, 1));
            cc = 1'($urandom_range(0, 1));
            d  = 3'($urandom_range(0, 7));
            s1 = ($urandom_range(0, 3) == 0) ? d : 3'($urandom_range(0, 7));
            s2 = ($urandom_range(0, 3) == 0) ? s1 : 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: w = 16'h0000;
                1: w = 16'h8000;
                2: w = 16'h7FFF;
                default: w = 16'($urandom);
            endcase
            apply(l, d, w, cc, s1, s2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
